// File: rtl/mask_serializer_pkg.sv
// Shared definitions for the mask serializer: state encoding, default width
// and the derivations of the index and count widths.
package mask_serializer_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to address one position of a width-bit word.
  function automatic int index_width(input int width);
    return $clog2(width);
  endfunction

  // Bits needed to hold a population count of 0..width inclusive.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mask_serializer_if.sv
// Handshake bundle between a mask producer, the serializer and its bit sink.
// master = the environment (producer + sink), slave = the serializer.
interface mask_serializer_if
  import mask_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  localparam int IW = index_width(WIDTH);
  localparam int CW = count_width(WIDTH);

  logic             in_valid;
  logic [WIDTH-1:0] in_mask;
  logic             in_ready;
  logic             out_valid;
  logic             out_bit;
  logic [IW-1:0]    out_index;
  logic             out_last;
  logic             out_ready;
  logic             count_valid;
  logic [CW-1:0]    ones_count;

  modport master (
    output in_valid, in_mask, out_ready,
    input  in_ready, out_valid, out_bit, out_index, out_last,
           count_valid, ones_count
  );

  modport slave (
    input  in_valid, in_mask, out_ready,
    output in_ready, out_valid, out_bit, out_index, out_last,
           count_valid, ones_count
  );

endinterface

// File: rtl/mask_serializer.sv
// Accepts one parallel mask word, streams it LSB-first under valid/ready and
// reports the number of set bits once the last bit has been taken.
module mask_serializer
  import mask_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)
(
  input  logic             clk,
  input  logic             rst_n,
  mask_serializer_if.slave bus
);

  localparam int IW = index_width(WIDTH);
  localparam int CW = count_width(WIDTH);

  state_t           state_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             count_valid_reg;

  // shreg_reg holds the bits not yet presented; out_bit_reg is the bit on the wire.
  logic [WIDTH-2:0] shreg_reg;
  logic             out_bit_reg;
  logic [IW-1:0]    index_reg;
  logic             out_last_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    ones_count_reg;

  logic load;
  logic beat;
  logic last_beat;

  assign load      = (state_reg == IDLE) && bus.in_valid;
  assign beat      = out_valid_reg && bus.out_ready;
  assign last_beat = beat && out_last_reg;

  // Control FSM: sequences IDLE -> SHIFT -> DONE and registers the handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      in_ready_reg    <= 1'b1;
      out_valid_reg   <= 1'b0;
      count_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            state_reg     <= SHIFT;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b1;
          end
        end
        SHIFT: begin
          if (last_beat) begin
            state_reg       <= DONE;
            out_valid_reg   <= 1'b0;
            count_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          state_reg       <= IDLE;
          count_valid_reg <= 1'b0;
          in_ready_reg    <= 1'b1;
        end
        default: begin
          state_reg       <= IDLE;
          in_ready_reg    <= 1'b1;
          out_valid_reg   <= 1'b0;
          count_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: shift register, bit index, running popcount and the final count.
  // Index and last flag are cleared on the final beat so index never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_reg      <= '0;
      out_bit_reg    <= 1'b0;
      index_reg      <= '0;
      out_last_reg   <= 1'b0;
      count_reg      <= '0;
      ones_count_reg <= '0;
    end else if (load) begin
      shreg_reg      <= bus.in_mask[WIDTH-1:1];
      out_bit_reg    <= bus.in_mask[0];
      index_reg      <= '0;
      out_last_reg   <= 1'b0;
      count_reg      <= '0;
      ones_count_reg <= '0;
    end else if (beat) begin
      count_reg <= count_reg + CW'(out_bit_reg);
      if (out_last_reg) begin
        ones_count_reg <= count_reg + CW'(out_bit_reg);
        shreg_reg      <= '0;
        out_bit_reg    <= 1'b0;
        index_reg      <= '0;
        out_last_reg   <= 1'b0;
      end else begin
        shreg_reg    <= shreg_reg >> 1;
        out_bit_reg  <= shreg_reg[0];
        index_reg    <= index_reg + 1'b1;
        out_last_reg <= (index_reg == IW'(WIDTH - 2));
      end
    end
  end

  assign bus.in_ready    = in_ready_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_bit     = out_bit_reg;
  assign bus.out_index   = index_reg;
  assign bus.out_last    = out_last_reg;
  assign bus.count_valid = count_valid_reg;
  assign bus.ones_count  = ones_count_reg;

endmodule

// File: tb/tb_mask_serializer.sv
// Directed bench for mask_serializer: streams hand-picked words, checks every
// presented bit, the DONE pulse timing and the final count.
module tb_mask_serializer;

  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;

  mask_serializer_if #(.WIDTH(32)) bus ();

  mask_serializer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference popcount of the word under test (mask_popcount).
  logic [31:0] ref_mask;
  logic [5:0]  ref_bit [32];
  logic [5:0]  mask_popcount;

  for (genvar gi = 0; gi < 32; gi++) begin : g_pop
    assign ref_bit[gi] = {5'd0, ref_mask[gi]};
  end

  // Sum the per-bit terms into the reference count.
  always_comb begin
    mask_popcount = '0;
    for (int i = 0; i < 32; i++) mask_popcount = mask_popcount + ref_bit[i];
  end

  // Load one word at the current negedge and follow its whole stream.
  task automatic run_word(input logic [31:0] mask, input bit toggle,
                          input logic [5:0] exp_count, input bit next_valid,
                          input logic [31:0] next_mask, input string tag);
    int k;
    int cyc;
    logic exp_bit;
    logic exp_last;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s in_ready_before_load: got %b want 1", tag, bus.in_ready);
    end
    bus.in_valid  = 1'b1;
    bus.in_mask   = mask;
    bus.out_ready = 1'b1;
    ref_mask      = mask;
    @(posedge clk);
    k   = 0;
    cyc = 0;
    while (k < 32 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.in_valid = next_valid;
        bus.in_mask  = next_mask;
      end
      exp_bit  = mask[k];
      exp_last = (k == 31);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_bit !== exp_bit || bus.out_index !== 5'(k) ||
          bus.out_last !== exp_last || bus.in_ready !== 1'b0 || bus.count_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s beat%0d: got v=%b bit=%b idx=%0d last=%b rdy=%b cv=%b want v=1 bit=%b idx=%0d last=%b rdy=0 cv=0",
                 tag, k, bus.out_valid, bus.out_bit, bus.out_index, bus.out_last,
                 bus.in_ready, bus.count_valid, exp_bit, k, exp_last);
      end
      bus.out_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      if (bus.out_ready) k++;
    end
    vectors++;
    if (k != 32) begin
      miscompares++;
      $display("FAIL %s stream_timeout: got %0d beats want 32", tag, k);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    cyc++;
    vectors++;
    if (bus.count_valid !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_flags: got cv=%b v=%b rdy=%b want cv=1 v=0 rdy=0",
               tag, bus.count_valid, bus.out_valid, bus.in_ready);
    end
    vectors++;
    if (bus.ones_count !== exp_count) begin
      miscompares++;
      $display("FAIL %s ones_count: got %0d want %0d", tag, bus.ones_count, exp_count);
    end
    vectors++;
    if (bus.ones_count !== mask_popcount) begin
      miscompares++;
      $display("FAIL %s ones_count_ref: got %0d want %0d", tag, bus.ones_count, mask_popcount);
    end
    if (!toggle) begin
      vectors++;
      if (cyc != 33) begin
        miscompares++;
        $display("FAIL %s done_cycle: got N+%0d want N+33", tag, cyc);
      end
    end
    @(negedge clk);
    cyc++;
    vectors++;
    if (bus.count_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.ones_count !== exp_count) begin
      miscompares++;
      $display("FAIL %s after_done: got cv=%b rdy=%b cnt=%0d want cv=0 rdy=1 cnt=%0d",
               tag, bus.count_valid, bus.in_ready, bus.ones_count, exp_count);
    end
    $display("txn %s mask=%08h ones=%0d cycles=%0d", tag, mask, bus.ones_count, cyc);
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mask   = '0;
    bus.out_ready = 1'b0;
    ref_mask      = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_bit !== 1'b0 ||
        bus.out_index !== 5'd0 || bus.out_last !== 1'b0 || bus.count_valid !== 1'b0 ||
        bus.ones_count !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_values: got rdy=%b v=%b bit=%b idx=%0d last=%b cv=%b cnt=%0d want 1 0 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_bit, bus.out_index, bus.out_last,
               bus.count_valid, bus.ones_count);
    end
    rst_n = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_hff();
    run_word(32'h0000_00ff, 1'b0, 6'd8, 1'b0, 32'h0, "hff");
  endtask

  task automatic test_all_ones();
    run_word(32'hffff_ffff, 1'b0, 6'd32, 1'b0, 32'h0, "all_ones");
  endtask

  task automatic test_zero();
    run_word(32'h0000_0000, 1'b0, 6'd0, 1'b0, 32'h0, "zero");
  endtask

  task automatic test_backpressure();
    run_word(32'h8000_0001, 1'b1, 6'd2, 1'b0, 32'h0, "backpressure");
  endtask

  task automatic test_back_to_back();
    run_word(32'h0000_00ff, 1'b0, 6'd8, 1'b1, 32'h0000_000f, "b2b_first");
    run_word(32'h0000_000f, 1'b0, 6'd4, 1'b0, 32'h0, "b2b_second");
  endtask

  task automatic test_reset_midstream();
    bit saw_output;
    bus.in_valid  = 1'b1;
    bus.in_mask   = 32'h0000_00ff;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (12) @(negedge clk);
    vectors++;
    if (bus.out_index !== 5'd12 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_position: got idx=%0d v=%b want idx=12 v=1", bus.out_index, bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_bit !== 1'b0 ||
        bus.out_index !== 5'd0 || bus.out_last !== 1'b0 || bus.count_valid !== 1'b0 ||
        bus.ones_count !== 6'd0) begin
      miscompares++;
      $display("FAIL rst_mid_values: got rdy=%b v=%b bit=%b idx=%0d last=%b cv=%b cnt=%0d want 1 0 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_bit, bus.out_index, bus.out_last,
               bus.count_valid, bus.ones_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_output = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.count_valid !== 1'b0 || bus.out_valid !== 1'b0) saw_output = 1'b1;
    end
    vectors++;
    if (saw_output) begin
      miscompares++;
      $display("FAIL rst_mid_no_count: got activity after reset want none");
    end
    $display("txn reset mid-stream at index 12");
    run_word(32'h0000_00ff, 1'b0, 6'd8, 1'b0, 32'h0, "after_reset");
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // Main sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_hff();
    test_all_ones();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mask_serializer.md
# mask_serializer

Downstream consumer of the 32-bit per-bit mask word built by the generate-loop mask stage. It accepts one parallel mask word over a valid/ready handshake and emits it LSB-first as a serial bit stream, also under valid/ready. It counts the set bits while streaming and reports the total once the last bit has been taken. Formal properties check it against the mask producer, e.g. an input of 'hff yields exactly eight leading ones.

## Interface
- WIDTH, 32, mask word width; legal range 2..32
- IW, $clog2(WIDTH), width of out_index (5 at default)
- CW, $clog2(WIDTH+1), width of ones_count (6 at default)

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  in_mask is valid
- in_mask  input  WIDTH  parallel mask word
- in_ready  output  1  block can accept a word
- out_valid  output  1  out_bit is valid
- out_bit  output  1  current mask bit
- out_index  output  IW  bit position of out_bit
- out_last  output  1  out_bit is bit WIDTH-1
- out_ready  input  1  sink takes out_bit this cycle
- count_valid  output  1  one-cycle pulse; ones_count is final
- ones_count  output  CW  number of 1s in the last word

## Operation
- State machine with three states:
  - IDLE: in_ready=1. If in_valid is high, load in_mask into the shift register, set index=0 and count=0, and go to SHIFT.
  - SHIFT: out_valid=1, out_bit=shreg[0], out_index=index, out_last=(index==WIDTH-1).
    - On out_valid&&out_ready: shift the register right by one, count+=out_bit, index+=1.
    - If out_last was set on that beat, go to DONE.
  - DONE: count_valid=1 and ones_count holds the final count. Return to IDLE unconditionally.
- ones_count holds its value after DONE until the next load, which clears it.
- in_ready=0 in SHIFT and DONE. in_valid asserted in those states is ignored and is not queued.
- out_bit, out_index and out_last are stable while out_valid=1 and out_ready=0.
- Arithmetic: count is CW bits wide. WIDTH ones gives exactly WIDTH with no wrap.
- index never wraps. It reaches WIDTH-1 and the state then leaves SHIFT.

## Timing
- Reset values (rst_n low, takes effect asynchronously):
  - state=IDLE, in_ready=1
  - out_valid=0, out_bit=0, out_index=0, out_last=0
  - count_valid=0, ones_count=0
- Load latency:
  - Accept edge N, and out_valid=1 at N+1 with bit 0.
  - One bit per cycle when out_ready is held high.
  - The last beat is taken at edge N+WIDTH.
  - count_valid is high during cycle N+WIDTH+1.
  - in_ready=1 again from cycle N+WIDTH+2.
  - Minimum period is WIDTH+2 cycles per word (34 at default).
- Backpressure: out_ready low stalls the stream with no bit lost or duplicated.
- Simultaneous events: in_valid and out_ready in the same IDLE cycle is a load only, since out_valid=0 in IDLE.
- Reset mid-stream: all registers clear immediately. The partial word is discarded and no count_valid is produced.
- rst_n deasserting: the first accept can occur at the first rising edge with rst_n high.

## Structure
- Shared package holds:
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - default WIDTH
  - IW and CW derivations
- No sub-module is needed: one always block for the state register and one for the datapath.
- The bench uses a combinational generate-loop reference popcount (mask_popcount) to check ones_count.

## Test plan
- Reset, then in_mask='hff with out_ready=1:
  - out_bit=1 for indices 0..7 and 0 for 8..31
  - out_last only at index 31
  - count_valid pulse with ones_count=8 at cycle N+33
- in_mask='hffffffff: 32 ones streamed; ones_count=32, which checks the 6-bit count with no wrap.
- in_mask=0: 32 zeros streamed; ones_count=0 and count_valid still pulses.
- in_mask='h80000001 with out_ready toggling 1,0,1,0:
  - each bit held across stalls
  - index sequence 0..31 without gaps
  - ones_count=2
- in_valid held high throughout: a second word ('h0000000f) is accepted only at cycle N+34, and its stream starts with index 0.
- rst_n pulsed low at index 12 of 'hff:
  - all outputs return to reset values
  - no count_valid is produced
  - the next word streams normally
